// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative restoring integer square root, one root bit per clock.
// The remainder output port exists only when SQRT_REM_OUT_EN is defined.
module sqrt_iter #(
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   sqrt_data,
  output logic [DATA_W/2-1:0] sqrt_root,
`ifdef SQRT_REM_OUT_EN
  output logic [DATA_W/2:0]   sqrt_rem,
`endif
  output logic                sqrt_valid,
  output logic                sqrt_busy
);

  localparam int ROOT_W = DATA_W / 2;
  localparam int REM_W  = ROOT_W + 2;
  localparam int CNT_W  = $clog2(ROOT_W);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROOT_W-1:0] root_out_q, root_out_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
`ifdef SQRT_REM_OUT_EN
  logic [ROOT_W:0]   rem_out_q, rem_out_d;
`endif

  logic [REM_W+1:0]  trial_s;
  logic [REM_W+1:0]  cmp_s;
  logic              ge_s;

  // Next-state, datapath step and output staging.
  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    root_d     = root_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    root_out_d = root_out_q;
    valid_d    = 1'b0;
`ifdef SQRT_REM_OUT_EN
    rem_out_d  = rem_out_q;
`endif
    trial_s = {rem_q, opnd_q[DATA_W-1 -: 2]};
    cmp_s   = {2'b00, root_q, 2'b01};
    ge_s    = (trial_s >= cmp_s);

    case (state_q)
      ST_LOAD: begin
        opnd_d  = sqrt_data;
        root_d  = {ROOT_W{1'b0}};
        rem_d   = {REM_W{1'b0}};
        cnt_d   = CNT_W'(ROOT_W - 1);
        state_d = ST_CALC;
      end
      ST_CALC: begin
        // Partial remainder never exceeds 2*root, so the top trial bits are zero.
        if (ge_s) begin
          rem_d  = REM_W'(trial_s - cmp_s);
          root_d = {root_q[ROOT_W-2:0], 1'b1};
        end else begin
          rem_d  = REM_W'(trial_s);
          root_d = {root_q[ROOT_W-2:0], 1'b0};
        end
        opnd_d = {opnd_q[DATA_W-3:0], 2'b00};
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        root_out_d = root_q;
`ifdef SQRT_REM_OUT_EN
        rem_out_d  = rem_q[ROOT_W:0];
`endif
        valid_d    = 1'b1;
        state_d    = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    busy_d = (state_d != ST_LOAD) ? 1'b1 : 1'b0;
  end

  // State and output registers with synchronous active-high reset on rst_n.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_LOAD;
      opnd_q     <= {DATA_W{1'b0}};
      root_q     <= {ROOT_W{1'b0}};
      rem_q      <= {REM_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      root_out_q <= {ROOT_W{1'b0}};
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SQRT_REM_OUT_EN
      rem_out_q  <= {(ROOT_W+1){1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      root_q     <= root_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      root_out_q <= root_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
`ifdef SQRT_REM_OUT_EN
      rem_out_q  <= rem_out_d;
`endif
    end
  end

  assign sqrt_root  = root_out_q;
  assign sqrt_valid = valid_q;
  assign sqrt_busy  = busy_q;
`ifdef SQRT_REM_OUT_EN
  assign sqrt_rem   = rem_out_q;
`endif

endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: directed-vector bench for sqrt_iter (frame timing, results, reset abort).
// Remainder checks are compiled in only with SQRT_REM_OUT_EN.
module tb_sqrt_iter;

  logic        clk;
  logic        rst_n;
  logic [63:0] sqrt_data;
  logic [31:0] sqrt_root;
  logic [32:0] sqrt_rem;
  logic        sqrt_valid;
  logic        sqrt_busy;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [63:0] vec_data [10];
  logic [31:0] vec_root [10];
  logic [32:0] vec_rem  [10];

`ifndef SQRT_REM_OUT_EN
  assign sqrt_rem = 33'd0;
`endif

  sqrt_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sqrt_data  (sqrt_data),
    .sqrt_root  (sqrt_root),
`ifdef SQRT_REM_OUT_EN
    .sqrt_rem   (sqrt_rem),
`endif
    .sqrt_valid (sqrt_valid),
    .sqrt_busy  (sqrt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for one valid pulse, checks frame length, busy and results, then presents next_data.
  task automatic run_frame(input string tag, input logic [63:0] next_data,
                           input logic [31:0] exp_root, input logic [32:0] exp_rem);
    int  cnt;
    bit  got;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check_val({tag, "_busy_calc"}, {63'd0, sqrt_busy}, 64'd1);
      if (cnt == 10) sqrt_data = 64'hA5A5_5A5A_DEAD_BEEF;
      if (sqrt_valid) got = 1'b1;
    end
    check_val({tag, "_cycles"}, 64'(cnt), 64'd34);
    if (got) begin
      check_val({tag, "_root"}, {32'd0, sqrt_root}, {32'd0, exp_root});
`ifdef SQRT_REM_OUT_EN
      check_val({tag, "_rem"}, {31'd0, sqrt_rem}, {31'd0, exp_rem});
`endif
      check_val({tag, "_busy_idle"}, {63'd0, sqrt_busy}, 64'd0);
    end
    sqrt_data = next_data;
  endtask

  initial begin
    vec_data[0] = 64'd16;                   vec_root[0] = 32'd4;          vec_rem[0] = 33'd0;
    vec_data[1] = 64'd16;                   vec_root[1] = 32'd4;          vec_rem[1] = 33'd0;
    vec_data[2] = 64'h00FF_FFFF_FFFF_FFFF;  vec_root[2] = 32'd268435455;  vec_rem[2] = 33'd536870910;
    vec_data[3] = 64'd4611686009837453316;  vec_root[3] = 32'd2147483646; vec_rem[3] = 33'd0;
    vec_data[4] = 64'd4611686014132420609;  vec_root[4] = 32'd2147483647; vec_rem[4] = 33'd0;
    vec_data[5] = 64'd400;                  vec_root[5] = 32'd20;         vec_rem[5] = 33'd0;
    vec_data[6] = 64'h0000_0000_0001_0001;  vec_root[6] = 32'd256;        vec_rem[6] = 33'd1;
    vec_data[7] = 64'd16000000;             vec_root[7] = 32'd4000;       vec_rem[7] = 33'd0;
    vec_data[8] = 64'd0;                    vec_root[8] = 32'd0;          vec_rem[8] = 33'd0;
    vec_data[9] = 64'hFFFF_FFFF_FFFF_FFFF;  vec_root[9] = 32'hFFFF_FFFF;  vec_rem[9] = 33'd8589934590;

    rst_n     = 1'b1;
    sqrt_data = vec_data[0];
    repeat (3) @(negedge clk);
    check_val("rst_root",  {32'd0, sqrt_root}, 64'd0);
    check_val("rst_rem",   {31'd0, sqrt_rem}, 64'd0);
    check_val("rst_valid", {63'd0, sqrt_valid}, 64'd0);
    check_val("rst_busy",  {63'd0, sqrt_busy}, 64'd0);
    rst_n = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_frame($sformatf("vec%0d", i), (i < 9) ? vec_data[i+1] : 64'd400, vec_root[i], vec_rem[i]);
    end

    // Abort a frame (operand 400) partway through CALC.
    repeat (15) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("abort_valid", {63'd0, sqrt_valid}, 64'd0);
    end
    check_val("abort_root", {32'd0, sqrt_root}, 64'd0);
    check_val("abort_rem",  {31'd0, sqrt_rem}, 64'd0);
    check_val("abort_busy", {63'd0, sqrt_busy}, 64'd0);
    sqrt_data = 64'd400;
    rst_n = 1'b0;
    run_frame("restart", 64'h0000_0000_0001_0001, 32'd20, 33'd0);
    run_frame("after", 64'd0, 32'd256, 33'd1);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
